// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: datapath widths, fetch FSM encoding and the
// 11-bit R/D-format opcodes used by the control decoder.
package legv8_pkg;

  localparam int PC_W     = 64;
  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 11;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_HOLD,
    FS_HALT
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_BRANCH
  } pc_sel_e;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 11'h458;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 11'h658;
  localparam logic [OPCODE_W-1:0] OP_AND  = 11'h450;
  localparam logic [OPCODE_W-1:0] OP_ORR  = 11'h550;
  localparam logic [OPCODE_W-1:0] OP_LDUR = 11'h7C2;
  localparam logic [OPCODE_W-1:0] OP_STUR = 11'h7C0;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1:INSTR_W-OPCODE_W];
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with its next-PC mux (hold, sequential +4, redirect).
// Arithmetic wraps modulo 2^64.
module fetch_pc
  import legv8_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_e         pc_sel,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      case (pc_sel)
        PC_INC:    pc <= pc + PC_W'(4);
        PC_BRANCH: pc <= br_target;
        default:   pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding request, registered INSTR/PC_OUT, branch
// redirect with kill of in-flight responses. Define FETCH_ALIGN_CHK_EN to halt on misaligned targets.
module fetch_unit
  import legv8_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                br_taken,
  input  logic [PC_W-1:0]     br_target,
  input  logic                stall,
  output logic                instr_valid,
  output logic [INSTR_W-1:0]  instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [PC_W-1:0]     pc_out,
  output logic                align_err
);

  fetch_state_e    state, state_nxt;
  logic            kill, kill_nxt;
  pc_sel_e         pc_sel;
  logic [PC_W-1:0] pc, target;
  logic            misaligned, redirect, accepted, consume, load;

`ifdef FETCH_ALIGN_CHK_EN
  assign target     = br_target;
  assign misaligned = br_taken && (br_target[1:0] != 2'b00) && (state != FS_HALT);
`else
  logic br_target_lsb_unused;
  assign br_target_lsb_unused = ^br_target[1:0];
  assign target     = {br_target[PC_W-1:2], 2'b00};
  assign misaligned = 1'b0;
`endif

  assign redirect = br_taken && !misaligned && (state != FS_HALT);
  assign accepted = imem_req && imem_gnt;
  assign consume  = instr_valid && !stall;

  fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_sel    (pc_sel),
    .br_target (target),
    .pc        (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FS_REQ;
      kill  <= 1'b0;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    kill_nxt  = kill;
    pc_sel    = PC_HOLD;
    load      = 1'b0;
    if (misaligned) begin
      state_nxt = FS_HALT;
    end else begin
      case (state)
        FS_REQ: begin
          if (redirect) begin
            pc_sel = PC_BRANCH;
            if (accepted) begin
              kill_nxt  = 1'b1;
              state_nxt = FS_WAIT;
            end
          end else if (accepted) begin
            state_nxt = FS_WAIT;
          end else if (instr_valid && stall) begin
            state_nxt = FS_HOLD;
          end
        end
        FS_WAIT: begin
          if (redirect) begin
            pc_sel = PC_BRANCH;
            if (imem_rvalid) begin
              kill_nxt  = 1'b0;
              state_nxt = FS_REQ;
            end else begin
              kill_nxt = 1'b1;
            end
          end else if (imem_rvalid) begin
            kill_nxt  = 1'b0;
            state_nxt = FS_REQ;
            if (!kill) begin
              load   = 1'b1;
              pc_sel = PC_INC;
            end
          end
        end
        FS_HOLD: begin
          if (redirect) begin
            pc_sel    = PC_BRANCH;
            state_nxt = FS_REQ;
          end else if (consume) begin
            state_nxt = FS_REQ;
          end
        end
        FS_HALT: state_nxt = FS_HALT;
        default: state_nxt = FS_REQ;
      endcase
    end
  end

  // Request is suppressed while decode holds a stalled instruction, and in reset.
  always_comb begin
    imem_req  = rst_n && (state == FS_REQ) && !(instr_valid && stall);
    imem_addr = pc;
    opcode    = opcode_of(instr);
  end

  // NOTE: these are plain flops with a cheap reset; resetting them makes
  // INSTR/PC_OUT deterministic, unlike a memory array that is left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instr       <= '0;
      pc_out      <= '0;
      align_err   <= 1'b0;
    end else begin
      if (misaligned) begin
        align_err <= 1'b1;
      end
      if (br_taken) begin
        instr_valid <= 1'b0;
      end else if (load) begin
        instr_valid <= 1'b1;
        instr       <= imem_rdata;
        pc_out      <= pc;
      end else if (consume) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 64'h0, first fetch address after reset.
REQ-002 Port: CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: RST_N  in  1  asynchronous, active-low reset.
REQ-004 Port: IMEM_REQ  out  1  fetch request valid.
REQ-005 Port: IMEM_ADDR  out  64  byte address of the request.
REQ-006 Port: IMEM_GNT  in  1  memory accepts the request this cycle.
REQ-007 Port: IMEM_RVALID  in  1  read data valid for the single outstanding request.
REQ-008 Port: IMEM_RDATA  in  32  instruction word.
REQ-009 Port: BR_TAKEN  in  1  one-cycle redirect pulse from the datapath.
REQ-010 Port: BR_TARGET  in  64  redirect address, sampled when BR_TAKEN=1.
REQ-011 Port: STALL  in  1  decode cannot accept INSTR this cycle.
REQ-012 Port: INSTR_VALID  out  1  INSTR/PC_OUT hold a live instruction.
REQ-013 Port: INSTR  out  32  registered instruction word.
REQ-014 Port: OPCODE  out  11  INSTR[31:21], combinational, feeds the control decoder.
REQ-015 Port: PC_OUT  out  64  address INSTR was fetched from.
REQ-016 Port: ALIGN_ERR  out  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-017 FSM states SHALL be REQ, WAIT, HOLD, HALT; at most one memory request outstanding.
REQ-018 REQ: IMEM_REQ=1, IMEM_ADDR=PC, held stable until IMEM_GNT; on GNT -> WAIT.
REQ-019 WAIT: IMEM_REQ=0; on IMEM_RVALID, INSTR<=IMEM_RDATA, PC_OUT<=PC, INSTR_VALID<=1, PC<=PC+4; -> REQ.
REQ-020 An instruction SHALL be consumed on any cycle with INSTR_VALID=1 and STALL=0; INSTR_VALID SHALL then clear next edge unless a new instruction loads the same edge.
REQ-021 REQ SHALL NOT assert IMEM_REQ while INSTR_VALID=1 and STALL=1; FSM moves to HOLD, returns to REQ on the consuming cycle.
REQ-022 Latency: GNT in cycle of request and RVALID one cycle later -> INSTR_VALID rises 2 cycles after IMEM_REQ first asserts; peak throughput one instruction per 2 cycles.
REQ-023 PC arithmetic SHALL be 64-bit modulo (64'hFFFF_FFFF_FFFF_FFFC + 4 = 0).
REQ-024 BR_TAKEN SHALL take priority over STALL and RVALID: PC<=BR_TARGET, INSTR_VALID<=0 at next edge.
REQ-025 BR_TAKEN in REQ without GNT: IMEM_ADDR changes to target next cycle (only permitted address change while ungranted).
REQ-026 BR_TAKEN in REQ with GNT, or in WAIT without RVALID: set KILL; next RVALID is discarded (no INSTR load, no PC+4), KILL cleared, -> REQ.
REQ-027 BR_TAKEN in WAIT with RVALID same cycle: response discarded, -> REQ.
REQ-028 BR_TAKEN in HOLD: -> REQ.
REQ-029 RVALID outside WAIT SHALL be ignored.

Reset
REQ-030 While RST_N=0: state=REQ, PC=RESET_PC, KILL=0, INSTR_VALID=0, INSTR=0, PC_OUT=0, ALIGN_ERR=0, IMEM_REQ=0.
REQ-031 IMEM_REQ SHALL assert in the first cycle after RST_N deasserts; reset mid-transaction abandons the outstanding request and ignores its late RVALID.

Configuration
REQ-032 Macro FETCH_ALIGN_CHK_EN defined: BR_TAKEN with BR_TARGET[1:0]!=0 sets ALIGN_ERR (sticky), INSTR_VALID<=0, FSM -> HALT (IMEM_REQ=0) until reset.
REQ-033 Macro undefined: BR_TARGET[1:0] forced to 2'b00, ALIGN_ERR tied 0, HALT unreachable.

Structure
REQ-034 Shared package legv8_pkg SHALL hold PC_W=64, INSTR_W=32, the fetch state enum, and the opcode constants the decoder already uses.
REQ-035 One sub-module fetch_pc SHALL hold the PC register and next-PC mux (RESET_PC, PC+4, BR_TARGET); FSM and output register stay in fetch_unit.

Verification
REQ-036 Reset, RESET_PC=0x400, GNT same cycle, RDATA=0x8B020020 after 1 cycle -> INSTR_VALID=1, PC_OUT=0x400, OPCODE=0x458, next IMEM_ADDR=0x404.
REQ-037 STALL=1 for 3 cycles with INSTR_VALID=1 -> INSTR held, IMEM_REQ=0; STALL drop -> one consume, request to next PC.
REQ-038 BR_TAKEN, BR_TARGET=0x1000 in WAIT, RVALID next cycle with 0xDEADBEEF -> word discarded, next IMEM_ADDR=0x1000, INSTR_VALID stays 0.
REQ-039 PC=0xFFFF_FFFF_FFFF_FFFC fetched -> next IMEM_ADDR=0.
REQ-040 GNT withheld 5 cycles -> IMEM_ADDR constant; RST_N pulsed in WAIT -> late RVALID ignored, fetch restarts at RESET_PC.
REQ-041 With FETCH_ALIGN_CHK_EN, BR_TARGET=0x1002 -> ALIGN_ERR=1, IMEM_REQ=0 until reset; without it -> fetch at 0x1000.
